// File: rtl/neogeo_video_pkg.sv
// Shared Neo Geo video constants: default raster timing, timer width and
// the bit positions of the two LSPC interrupt sources in the ack vector.
package neogeo_video_pkg;

  localparam int H_TOTAL     = 384;
  localparam int V_TOTAL     = 264;
  localparam int HSYNC_W     = 32;
  localparam int H_ACT_START = 56;
  localparam int H_ACT_END   = 376;
  localparam int VSYNC_W     = 8;
  localparam int V_ACT_START = 16;
  localparam int V_ACT_END   = 240;

  localparam int CNT_W   = 9;
  localparam int TIMER_W = 32;

  localparam int IRQ_TIMER_BIT = 0;
  localparam int IRQ_VBL_BIT   = 1;

endpackage

// File: rtl/lspc_pixel_timer.sv
// Programmable pixel-rate countdown timer with a latched interrupt request.
// A reload value N expires every N+1 enabled pixels; a CPU write always
// takes priority over counting and suppresses the expiry in that cycle.
module lspc_pixel_timer
  import neogeo_video_pkg::*;
(
  input  logic               CLK_12M,
  input  logic               nRESETP,
  input  logic               i_pixEn,
  input  logic               i_timerWe,
  input  logic [TIMER_W-1:0] i_timerData,
  input  logic               i_timerEn,
  input  logic               i_irqAck,
  output logic               o_irqTimer
);

  logic [TIMER_W-1:0] r_reload;
  logic [TIMER_W-1:0] r_count;
  logic               r_irq;
  logic               w_expire;

  assign w_expire = i_pixEn && i_timerEn && !i_timerWe && (r_count == '0);

  // Reload register and countdown; zero reloads instead of underflowing.
  always_ff @(posedge CLK_12M or negedge nRESETP) begin
    if (!nRESETP) begin
      r_reload <= '0;
      r_count  <= '0;
    end else if (i_timerWe) begin
      r_reload <= i_timerData;
      r_count  <= i_timerData;
    end else if (i_pixEn && i_timerEn) begin
      if (w_expire) begin
        r_count <= r_reload;
      end else begin
        r_count <= r_count - {{(TIMER_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Interrupt latch: expiry sets it and beats a simultaneous acknowledge.
  always_ff @(posedge CLK_12M or negedge nRESETP) begin
    if (!nRESETP) begin
      r_irq <= 1'b0;
    end else if (w_expire) begin
      r_irq <= 1'b1;
    end else if (i_irqAck) begin
      r_irq <= 1'b0;
    end
  end

  assign o_irqTimer = r_irq;

endmodule

// File: rtl/lspc_video_timing.sv
// LSPC video timing: 6 MHz pixel enable, raster counters, registered
// sync/blank strobes, the VBL interrupt latch and the pixel timer.
// Strobes decode the next counter values so they line up with the counters.
module lspc_video_timing #(
  parameter int H_TOTAL     = neogeo_video_pkg::H_TOTAL,
  parameter int V_TOTAL     = neogeo_video_pkg::V_TOTAL,
  parameter int HSYNC_W     = neogeo_video_pkg::HSYNC_W,
  parameter int H_ACT_START = neogeo_video_pkg::H_ACT_START,
  parameter int H_ACT_END   = neogeo_video_pkg::H_ACT_END,
  parameter int VSYNC_W     = neogeo_video_pkg::VSYNC_W,
  parameter int V_ACT_START = neogeo_video_pkg::V_ACT_START,
  parameter int V_ACT_END   = neogeo_video_pkg::V_ACT_END
) (
  input  logic        CLK_12M,
  input  logic        nRESETP,
  input  logic        TIMER_WE,
  input  logic [31:0] TIMER_DATA,
  input  logic        TIMER_EN,
  input  logic [1:0]  IRQ_ACK,
  output logic        PIX_EN,
  output logic [8:0]  PIXELC,
  output logic [8:0]  RASTERC,
  output logic        nHSYNC,
  output logic        nVSYNC,
  output logic        nBNK,
  output logic        IRQ_VBL,
  output logic        IRQ_TIMER
);

  localparam logic [8:0] C_H_LAST   = 9'(H_TOTAL - 1);
  localparam logic [8:0] C_V_LAST   = 9'(V_TOTAL - 1);
  localparam logic [8:0] C_HSYNC    = 9'(HSYNC_W);
  localparam logic [8:0] C_VSYNC    = 9'(VSYNC_W);
  localparam logic [8:0] C_H_ACT_S  = 9'(H_ACT_START);
  localparam logic [8:0] C_H_ACT_E  = 9'(H_ACT_END);
  localparam logic [8:0] C_V_ACT_S  = 9'(V_ACT_START);
  localparam logic [8:0] C_V_ACT_E  = 9'(V_ACT_END);

  logic       r_phase;
  logic       r_pixEn;
  logic [8:0] r_pixelc;
  logic [8:0] r_rasterc;
  logic       r_nHsync;
  logic       r_nVsync;
  logic       r_nBnk;
  logic       r_irqVbl;
  logic [8:0] w_pixelNext;
  logic [8:0] w_rasterNext;
  logic       w_vblSet;

  // Half-rate phase; the pixel enable is high while the phase is 1.
  always_ff @(posedge CLK_12M or negedge nRESETP) begin
    if (!nRESETP) begin
      r_phase <= 1'b0;
      r_pixEn <= 1'b0;
    end else begin
      r_phase <= ~r_phase;
      r_pixEn <= ~r_phase;
    end
  end

  // Next raster position: advance one pixel per pixel enable, wrap line then frame.
  always_comb begin
    w_pixelNext  = r_pixelc;
    w_rasterNext = r_rasterc;
    if (r_pixEn) begin
      if (r_pixelc == C_H_LAST) begin
        w_pixelNext  = '0;
        w_rasterNext = (r_rasterc == C_V_LAST) ? 9'd0 : r_rasterc + 9'd1;
      end else begin
        w_pixelNext = r_pixelc + 9'd1;
      end
    end
  end

  assign w_vblSet = r_pixEn && (w_pixelNext == 9'd0) && (w_rasterNext == C_V_ACT_E);

  // Counters and strobes registered together from the same next position.
  always_ff @(posedge CLK_12M or negedge nRESETP) begin
    if (!nRESETP) begin
      r_pixelc  <= '0;
      r_rasterc <= '0;
      r_nHsync  <= 1'b0;
      r_nVsync  <= 1'b0;
      r_nBnk    <= 1'b0;
    end else begin
      r_pixelc  <= w_pixelNext;
      r_rasterc <= w_rasterNext;
      r_nHsync  <= !(w_pixelNext < C_HSYNC);
      r_nVsync  <= !(w_rasterNext < C_VSYNC);
      r_nBnk    <= (w_pixelNext >= C_H_ACT_S) && (w_pixelNext < C_H_ACT_E) &&
                   (w_rasterNext >= C_V_ACT_S) && (w_rasterNext < C_V_ACT_E);
    end
  end

  // VBL latch: set on entering the first blanked line, set beats acknowledge.
  always_ff @(posedge CLK_12M or negedge nRESETP) begin
    if (!nRESETP) begin
      r_irqVbl <= 1'b0;
    end else if (w_vblSet) begin
      r_irqVbl <= 1'b1;
    end else if (IRQ_ACK[neogeo_video_pkg::IRQ_VBL_BIT]) begin
      r_irqVbl <= 1'b0;
    end
  end

  lspc_pixel_timer u_timer (
    .CLK_12M     (CLK_12M),
    .nRESETP     (nRESETP),
    .i_pixEn     (r_pixEn),
    .i_timerWe   (TIMER_WE),
    .i_timerData (TIMER_DATA),
    .i_timerEn   (TIMER_EN),
    .i_irqAck    (IRQ_ACK[neogeo_video_pkg::IRQ_TIMER_BIT]),
    .o_irqTimer  (IRQ_TIMER)
  );

  assign PIX_EN  = r_pixEn;
  assign PIXELC  = r_pixelc;
  assign RASTERC = r_rasterc;
  assign nHSYNC  = r_nHsync;
  assign nVSYNC  = r_nVsync;
  assign nBNK    = r_nBnk;
  assign IRQ_VBL = r_irqVbl;

endmodule

// File: tb/tb_lspc_video_timing.sv
// Testbench for lspc_video_timing with a shortened frame (16 lines) so that
// two VBL periods fit in a short run; horizontal timing keeps its defaults.
module tb_lspc_video_timing;

  localparam int H_T  = 384;
  localparam int HS_W = 32;
  localparam int HA_S = 56;
  localparam int HA_E = 376;
  localparam int V_T  = 16;
  localparam int VS_W = 3;
  localparam int VA_S = 4;
  localparam int VA_E = 12;
  localparam longint FRAME_PIX = 6144;
  localparam longint FRAME_CYC = 12288;

  logic        CLK_12M;
  logic        nRESETP;
  logic        TIMER_WE;
  logic [31:0] TIMER_DATA;
  logic        TIMER_EN;
  logic [1:0]  IRQ_ACK;
  logic        PIX_EN;
  logic [8:0]  PIXELC;
  logic [8:0]  RASTERC;
  logic        nHSYNC;
  logic        nVSYNC;
  logic        nBNK;
  logic        IRQ_VBL;
  logic        IRQ_TIMER;

  int tests  = 0;
  int errors = 0;

  longint mCycle   = 0;
  longint mReload  = 0;
  longint mElapsed = 0;
  logic   mVbl     = 1'b0;
  logic   mTirq    = 1'b0;

  bit statOn  = 1'b0;
  int pixSeen = 0;
  int hsLow   = 0;
  int vsLow   = 0;
  int bnkHigh = 0;

  lspc_video_timing #(
    .V_TOTAL     (V_T),
    .VSYNC_W     (VS_W),
    .V_ACT_START (VA_S),
    .V_ACT_END   (VA_E)
  ) dut (
    .CLK_12M    (CLK_12M),
    .nRESETP    (nRESETP),
    .TIMER_WE   (TIMER_WE),
    .TIMER_DATA (TIMER_DATA),
    .TIMER_EN   (TIMER_EN),
    .IRQ_ACK    (IRQ_ACK),
    .PIX_EN     (PIX_EN),
    .PIXELC     (PIXELC),
    .RASTERC    (RASTERC),
    .nHSYNC     (nHSYNC),
    .nVSYNC     (nVSYNC),
    .nBNK       (nBNK),
    .IRQ_VBL    (IRQ_VBL),
    .IRQ_TIMER  (IRQ_TIMER)
  );

  // 12 MHz clock, 10 time units per period.
  initial begin
    CLK_12M = 1'b0;
    forever #5 CLK_12M = ~CLK_12M;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, mCycle);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] data, input logic en, input logic [1:0] ack);
    TIMER_WE   = we;
    TIMER_DATA = data;
    TIMER_EN   = en;
    IRQ_ACK    = ack;
  endtask

  task automatic waitCycle(input longint target);
    int guard;
    guard = 0;
    while (mCycle < target && guard < 40000) begin
      @(negedge CLK_12M);
      guard++;
    end
    if (mCycle != target) checkOutput("wait reached cycle", 64'(mCycle), 64'(target));
  endtask

  // Expected outputs from the raster position implied by the edge count since reset.
  function automatic logic [23:0] modelOutputs();
    longint pos;
    int px;
    int ln;
    pos = (mCycle / 2) % FRAME_PIX;
    px  = int'(pos % H_T);
    ln  = int'(pos / H_T);
    return {(mCycle % 2) == 1, 9'(px), 9'(ln), !(px < HS_W), !(ln < VS_W),
            (px >= HA_S) && (px < HA_E) && (ln >= VA_S) && (ln < VA_E), mVbl, mTirq};
  endfunction

  // Reference model: edge count, VBL latch, and timer as elapsed enabled pixels since load.
  always @(posedge CLK_12M or negedge nRESETP) begin : model
    longint nextCycle;
    longint nextElapsed;
    longint pos;
    logic   adv;
    logic   vSet;
    logic   tSet;
    if (!nRESETP) begin
      mCycle   <= 0;
      mVbl     <= 1'b0;
      mTirq    <= 1'b0;
      mReload  <= 0;
      mElapsed <= 0;
    end else begin
      nextCycle = mCycle + 1;
      adv  = (nextCycle % 2) == 0;
      pos  = (nextCycle / 2) % FRAME_PIX;
      vSet = adv && (pos == longint'(VA_E * H_T));
      tSet = 1'b0;
      mCycle <= nextCycle;
      if (vSet) mVbl <= 1'b1;
      else if (IRQ_ACK[1]) mVbl <= 1'b0;
      if (TIMER_WE) begin
        mReload  <= longint'({32'd0, TIMER_DATA});
        mElapsed <= 0;
      end else if (adv && TIMER_EN) begin
        nextElapsed = mElapsed + 1;
        mElapsed <= nextElapsed;
        tSet = (nextElapsed % (mReload + 1)) == 0;
      end
      if (tSet) mTirq <= 1'b1;
      else if (IRQ_ACK[0]) mTirq <= 1'b0;
    end
  end

  // Every cycle, all outputs against the model.
  always @(negedge CLK_12M) begin : compare
    checkOutput("per-cycle outputs",
                64'({PIX_EN, PIXELC, RASTERC, nHSYNC, nVSYNC, nBNK, IRQ_VBL, IRQ_TIMER}),
                64'(modelOutputs()));
  end

  // Per-pixel statistics over the first frame after reset release.
  always @(negedge CLK_12M) begin : stats
    if (statOn && nRESETP && mCycle < FRAME_CYC && PIX_EN) begin
      pixSeen++;
      if (!nHSYNC) hsLow++;
      if (!nVSYNC) vsLow++;
      if (nBNK) bnkHigh++;
    end
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #900000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin : stimulus
    int guard;
    int pixCnt;
    int enPix;
    bit frozen;

    nRESETP = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 2'b00);
    repeat (3) @(negedge CLK_12M);
    checkOutput("reset PIX_EN", 64'(PIX_EN), 64'd0);
    checkOutput("reset PIXELC", 64'(PIXELC), 64'd0);
    checkOutput("reset nHSYNC", 64'(nHSYNC), 64'd0);
    checkOutput("reset nBNK", 64'(nBNK), 64'd0);
    checkOutput("reset IRQs", 64'({IRQ_VBL, IRQ_TIMER}), 64'd0);

    @(posedge CLK_12M);
    #2 nRESETP = 1'b1;
    statOn = 1'b1;
    @(negedge CLK_12M);
    checkOutput("first cycle PIX_EN", 64'(PIX_EN), 64'd0);
    @(negedge CLK_12M);
    checkOutput("edge1 PIX_EN", 64'(PIX_EN), 64'd1);
    checkOutput("edge1 PIXELC", 64'(PIXELC), 64'd0);
    @(negedge CLK_12M);
    checkOutput("edge2 PIX_EN", 64'(PIX_EN), 64'd0);
    checkOutput("edge2 PIXELC", 64'(PIXELC), 64'd1);
    waitCycle(767);
    checkOutput("line end PIXELC", 64'(PIXELC), 64'd383);
    checkOutput("line end RASTERC", 64'(RASTERC), 64'd0);
    @(negedge CLK_12M);
    checkOutput("wrap PIXELC", 64'(PIXELC), 64'd0);
    checkOutput("wrap RASTERC", 64'(RASTERC), 64'd1);

    guard = 0;
    while (!IRQ_VBL && guard < 20000) begin
      @(negedge CLK_12M);
      guard++;
    end
    checkOutput("VBL rise cycle", 64'(mCycle), 64'd9216);
    checkOutput("VBL rise PIXELC", 64'(PIXELC), 64'd0);
    checkOutput("VBL rise RASTERC", 64'(RASTERC), 64'd12);
    repeat (9) @(negedge CLK_12M);
    applyStimulus(1'b0, 32'd0, 1'b0, 2'b10);
    @(negedge CLK_12M);
    applyStimulus(1'b0, 32'd0, 1'b0, 2'b00);
    checkOutput("VBL cleared by ack", 64'(IRQ_VBL), 64'd0);

    waitCycle(FRAME_CYC);
    statOn = 1'b0;
    checkOutput("frame pixel count", 64'(pixSeen), 64'd6144);
    checkOutput("frame nHSYNC low pixels", 64'(hsLow), 64'd512);
    checkOutput("frame nVSYNC low pixels", 64'(vsLow), 64'd1152);
    checkOutput("frame nBNK high pixels", 64'(bnkHigh), 64'd2560);

    waitCycle(21503);
    checkOutput("VBL low before next frame set", 64'(IRQ_VBL), 64'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 2'b10);
    @(negedge CLK_12M);
    applyStimulus(1'b0, 32'd0, 1'b0, 2'b00);
    checkOutput("VBL set beats ack", 64'(IRQ_VBL), 64'd1);
    checkOutput("second VBL RASTERC", 64'(RASTERC), 64'd12);

    applyStimulus(1'b1, 32'd5, 1'b1, 2'b00);
    @(negedge CLK_12M);
    applyStimulus(1'b0, 32'd0, 1'b1, 2'b00);
    pixCnt = 0;
    guard  = 0;
    while (!IRQ_TIMER && guard < 200) begin
      if (PIX_EN) pixCnt++;
      @(negedge CLK_12M);
      guard++;
    end
    checkOutput("timer first period", 64'(pixCnt), 64'd6);
    applyStimulus(1'b0, 32'd0, 1'b1, 2'b01);
    @(negedge CLK_12M);
    applyStimulus(1'b0, 32'd0, 1'b1, 2'b00);
    checkOutput("timer cleared by ack", 64'(IRQ_TIMER), 64'd0);
    pixCnt = 0;
    guard  = 0;
    while (!IRQ_TIMER && guard < 200) begin
      if (PIX_EN) pixCnt++;
      @(negedge CLK_12M);
      guard++;
    end
    checkOutput("timer second period", 64'(pixCnt), 64'd6);

    applyStimulus(1'b0, 32'd0, 1'b1, 2'b01);
    @(negedge CLK_12M);
    applyStimulus(1'b0, 32'd0, 1'b1, 2'b00);
    pixCnt = 0;
    guard  = 0;
    while (guard < 100) begin
      if (PIX_EN) begin
        if (pixCnt == 5) break;
        pixCnt++;
      end
      @(negedge CLK_12M);
      guard++;
    end
    applyStimulus(1'b1, 32'd100, 1'b1, 2'b00);
    @(negedge CLK_12M);
    applyStimulus(1'b0, 32'd0, 1'b1, 2'b00);
    checkOutput("load beats expiry", 64'(IRQ_TIMER), 64'd0);

    enPix  = 0;
    frozen = 1'b0;
    guard  = 0;
    while (guard < 1000) begin
      if (enPix == 50 && !frozen) begin
        applyStimulus(1'b0, 32'd0, 1'b0, 2'b00);
        repeat (40) @(negedge CLK_12M);
        checkOutput("timer frozen no IRQ", 64'(IRQ_TIMER), 64'd0);
        frozen = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b1, 2'b00);
      end
      if (IRQ_TIMER) break;
      if (PIX_EN && TIMER_EN) enPix++;
      @(negedge CLK_12M);
      guard++;
    end
    checkOutput("timer reload 100 period", 64'(enPix), 64'd101);
    applyStimulus(1'b0, 32'd0, 1'b0, 2'b00);
    repeat (20) @(negedge CLK_12M);
    checkOutput("timer IRQ held while disabled", 64'(IRQ_TIMER), 64'd1);

    guard = 0;
    while (!(RASTERC == 9'd13 && PIXELC == 9'd200) && guard < 30000) begin
      @(negedge CLK_12M);
      guard++;
    end
    checkOutput("pre-reset IRQs pending", 64'({IRQ_VBL, IRQ_TIMER}), 64'd3);
    @(posedge CLK_12M);
    #2 nRESETP = 1'b0;
    #1;
    checkOutput("async reset PIXELC", 64'(PIXELC), 64'd0);
    checkOutput("async reset RASTERC", 64'(RASTERC), 64'd0);
    checkOutput("async reset strobes", 64'({PIX_EN, nHSYNC, nVSYNC, nBNK}), 64'd0);
    checkOutput("async reset IRQs", 64'({IRQ_VBL, IRQ_TIMER}), 64'd0);
    repeat (2) @(negedge CLK_12M);
    @(posedge CLK_12M);
    #2 nRESETP = 1'b1;
    @(negedge CLK_12M);
    checkOutput("restart first cycle PIX_EN", 64'(PIX_EN), 64'd0);
    @(negedge CLK_12M);
    checkOutput("restart edge1 PIXELC", 64'(PIXELC), 64'd0);
    @(negedge CLK_12M);
    checkOutput("restart edge2 position", 64'({RASTERC, PIXELC}), 64'd1);
    repeat (10) @(negedge CLK_12M);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/lspc_video_timing.md
Name: lspc_video_timing

Overview:
- Video timing generator, downstream of the system clock divider; runs from CLK_12M.
- Derives a 6 MHz pixel enable and horizontal/vertical raster counters.
- Produces sync/blanking strobes and two latched interrupt requests for the 68K interrupt logic:
  - VBL: start of vertical blank.
  - TIMER: programmable 32-bit pixel-rate countdown.

Parameters:
- H_TOTAL, 384, pixels per line.
- V_TOTAL, 264, lines per frame.
- HSYNC_W, 32, nHSYNC low width in pixels, starting at pixel 0.
- H_ACT_START, 56, first active pixel.
- H_ACT_END, 376, first blanked pixel after the active region.
- VSYNC_W, 8, nVSYNC low width in lines, starting at line 0.
- V_ACT_START, 16, first active line.
- V_ACT_END, 240, first blanked line; the VBL IRQ fires here.

Ports:
- CLK_12M  in  1  system clock, 12 MHz, all logic on posedge.
- nRESETP  in  1  reset, asynchronous, active-low.
- TIMER_WE  in  1  one-cycle write strobe for the timer reload value.
- TIMER_DATA  in  32  reload value.
- TIMER_EN  in  1  timer count enable (level).
- IRQ_ACK  in  2  one-cycle acknowledge strobes; bit0 = timer, bit1 = VBL.
- PIX_EN  out  1  one-cycle pixel enable, every 2nd CLK_12M.
- PIXELC  out  9  horizontal count, 0..H_TOTAL-1.
- RASTERC  out  9  line count, 0..V_TOTAL-1.
- nHSYNC  out  1  active-low horizontal sync.
- nVSYNC  out  1  active-low vertical sync.
- nBNK  out  1  active-low blanking (0 = blanked).
- IRQ_VBL  out  1  latched VBL interrupt request.
- IRQ_TIMER  out  1  latched timer interrupt request.

Behaviour:
- Reset: asynchronous on nRESETP low; all state cleared. Reset values:
  - phase = 0, PIX_EN = 0, PIXELC = 0, RASTERC = 0.
  - nHSYNC = 0, nVSYNC = 0, nBNK = 0.
  - IRQ_VBL = 0, IRQ_TIMER = 0.
  - Timer counter = 0, reload register = 0.
- Phase and PIX_EN:
  - phase toggles every CLK_12M.
  - PIX_EN is registered = 1 in the cycle where phase = 1; it is 0 in the first cycle after reset release.
- Counters advance only on PIX_EN cycles.
  - PIXELC wraps H_TOTAL-1 -> 0.
  - On that wrap, RASTERC increments and wraps V_TOTAL-1 -> 0.
- Strobes are registered, so they are valid in the same cycle as the counter values they decode:
  - nHSYNC = 0 iff PIXELC < HSYNC_W.
  - nVSYNC = 0 iff RASTERC < VSYNC_W.
  - nBNK = 1 iff H_ACT_START <= PIXELC < H_ACT_END and V_ACT_START <= RASTERC < V_ACT_END.
- VBL IRQ:
  - Set event: the PIX_EN cycle in which the counters become (PIXELC = 0, RASTERC = V_ACT_END); IRQ_VBL rises in the same cycle.
  - Clear: IRQ_ACK[1] on a later cycle.
  - Set and ack in the same cycle: set wins, IRQ_VBL stays 1.
- Timer datapath:
  - TIMER_WE loads both the reload register and the counter from TIMER_DATA, regardless of TIMER_EN.
  - On a PIX_EN cycle with TIMER_EN = 1 and no TIMER_WE:
    - counter != 0: counter -= 1.
    - counter == 0: counter <= reload, and IRQ_TIMER set.
  - A reload value N therefore gives a period of N+1 pixels.
  - TIMER_WE coinciding with a decrement: the load wins, no IRQ is raised that cycle.
  - TIMER_EN = 0: the counter holds its value; a pending IRQ is kept.
- Timer IRQ:
  - Cleared by IRQ_ACK[0].
  - Set and ack in the same cycle: set wins.
- Width rules:
  - Counters are 9-bit unsigned; parameters must satisfy H_TOTAL, V_TOTAL <= 512.
  - Timer arithmetic is 32-bit unsigned with no underflow: zero always triggers the reload.
- Mid-frame reset: everything returns to reset values; after release the frame restarts at (0,0) on the 2nd CLK_12M edge.

Decomposition:
- Shared package neogeo_video_pkg holds:
  - default timing constants (H_TOTAL, V_TOTAL, sync/active bounds);
  - IRQ index constants (IRQ_TIMER_BIT = 0, IRQ_VBL_BIT = 1).
- One natural sub-module: lspc_pixel_timer.
  - Contains the 32-bit reload/countdown and the IRQ_TIMER latch.
  - Inputs: PIX_EN, TIMER_WE, TIMER_DATA, TIMER_EN, ack bit0.
- Raster counters, sync decode and the VBL latch stay in the top module.

Test Plan:
- Reset release, TIMER_EN = 0 -> PIX_EN toggles with period 2; PIXELC reaches 383 then wraps to 0 with RASTERC = 1 after exactly 768 CLK_12M cycles.
- Free-run one full frame -> nHSYNC low for 32 pixels per line; nVSYNC low for lines 0..7; nBNK high for exactly 320 × 224 = 71680 pixels; frame length 202752 CLK_12M cycles.
- VBL -> IRQ_VBL rises as the counters become (0, 240); ack 10 cycles later clears it; next rise exactly 202752 cycles after the first; ack coincident with set -> stays 1.
- TIMER_WE with 5, TIMER_EN = 1 -> IRQ_TIMER set after 6 PIX_EN cycles, counter reloads to 5; ack; next set after 6 more PIX_EN.
- TIMER_WE with 100 asserted on the PIX_EN cycle where the counter is 0 -> counter = 100, no IRQ; TIMER_EN dropped mid-count -> value frozen, resumes on re-enable.
- nRESETP pulsed low at line 120, pixel 200 with both IRQs pending -> all outputs immediately return to reset values; counting restarts from (0,0).
